axi4_modport_slave_mem: RTL and testbench
=========================================

// Module: axi4_modport_slave_mem
// PURPOSE
//  AXI4 (full) slave endpoint backed by a word-addressed on-chip RAM. It attaches to the slave side of an
//  AXI4 interface bundle and serves one write burst and one read burst at a time.
//  The write and read paths are fully independent of each other. Used as a reference target for
//  master BFMs, the passive monitor and protocol assertions.
// PARAMETERS
//  ADDR_W    32    address width (bytes)
//  DATA_W    64    data width; multiple of 8, power of two >= 8
//  ID_W      4     transaction ID width
//  USER_W    1     user-signal width
//  MEM_DEPTH 1024  RAM depth in DATA_W words
// PORTS
//  aclk      in   1         clock, all logic on rising edge
//  areset    in   1         synchronous reset, active high
//  awid,awaddr,awlen[8],awsize[3],awburst[2]   in  AW payload
//  awlock,awcache,awprot,awqos,awregion,awuser in  accepted and ignored
//  awvalid in 1 / awready out 1                    AW handshake
//  wdata in DATA_W, wstrb in DATA_W/8, wlast in 1  W payload; wuser in, ignored
//  wvalid in 1 / wready out 1                      W handshake
//  bid out ID_W, bresp out 2, buser out USER_W     B payload
//  bvalid out 1 / bready in 1                      B handshake
//  arid,araddr,arlen,arsize,arburst in             AR payload; other AR sidebands in, ignored
//  arvalid in 1 / arready out 1                    AR handshake
//  rid out ID_W, rdata out DATA_W, rresp out 2, rlast out 1, ruser out USER_W   R payload
//  rvalid out 1 / rready in 1                      R handshake
// BEHAVIOUR
//  Reset: all outputs 0 (awready, wready, arready, bvalid, rvalid, rlast, IDs, resp, data, user).
//   RAM contents are not cleared. A reset mid-burst aborts the burst and drops any pending response.
//  Outputs are registered. buser and ruser are always 0. Response codes: OKAY=2'b00, SLVERR=2'b10.
//  Write FSM WIDLE->WDATA->WRESP->WIDLE:
//   WIDLE:  awready=1. On awvalid&&awready, latch id/addr/len/size/burst and go to WDATA;
//           awready falls in the next cycle.
//   WDATA:  wready=1. On each W handshake, write the bytes selected by wstrb into word addr>>log2(DATA_W/8),
//           then advance the address.
//           A beat with wlast=1 ends the burst: go to WRESP with bvalid=1 in the next cycle.
//   WRESP:  hold bvalid, bid and bresp until bready; then return to WIDLE with awready=1 in the next cycle.
//   bresp=SLVERR if any of the following occurred, otherwise OKAY:
//    - any beat was out of range (word index >= MEM_DEPTH);
//    - wlast did not arrive on beat awlen, or a beat past awlen arrived without wlast
//      (the burst still ends only on wlast; excess beats are not written);
//    - awburst==2'b11;
//    - WRAP with len not in {1,3,7,15}.
//   An out-of-range beat is not written.
//  Read FSM RIDLE->RDATA->RIDLE:
//   RIDLE:  arready=1. On AR handshake, latch fields and go to RDATA; rvalid=1 with beat 0 in the next cycle.
//   RDATA:  rdata, rid, rresp and rlast stay stable while rvalid && !rready.
//           On handshake, present the next beat in the next cycle (1 beat/cycle with rready held high).
//           rlast=1 on beat arlen. After the last handshake return to RIDLE with arready=1.
//   Per-beat rresp=SLVERR (rdata=0) when the beat is out of range.
//   All beats of a reserved-burst or illegal-WRAP read return SLVERR.
//   rdata is always the full word; no lane masking is applied for narrow sizes.
//  Address update per beat, where incr = 1<<size:
//   FIXED:           address unchanged.
//   INCR / reserved: addr += incr.
//   WRAP:            mask = (len+1)*incr-1; addr = (addr & ~mask) | ((addr+incr) & mask).
//   No 4KB-boundary check. size > log2(DATA_W/8) is treated as full width.
//  Same-cycle read and write to the same word: the read beat sampled that cycle returns the pre-write data.
//  Any read launched after a B handshake observes that write.
// TESTING
//  1 INCR write: awaddr=0x100, awlen=3, size=3, wdata=0x11..,0x22..,0x33..,0x44.., wstrb=0xFF
//    -> 4 beats accepted, bresp=OKAY, bid=awid.
//    Then read the same burst -> rdata in the same order, rlast on beat 3, rresp=OKAY.
//  2 Byte strobes: write 0xFFFF_FFFF_FFFF_FFFF to 0x0, then 0x0 with wstrb=0x01
//    -> read of 0x0 returns 0xFFFF_FFFF_FFFF_FF00.
//  3 WRAP read: araddr=0x18, arlen=3, size=3 -> words are read from 0x18, 0x00, 0x08, 0x10.
//    FIXED read with arlen=2 -> the same word 3 times.
//  4 Out of range: write to byte address MEM_DEPTH*8 -> bresp=SLVERR and the RAM is unchanged.
//    Read of the same address -> rresp=SLVERR, rdata=0.
//  5 Backpressure and reset:
//    - hold bready=0 for 5 cycles -> bvalid and bid stay stable;
//    - toggle rready mid-burst -> R payload stays stable;
//    - assert areset during RDATA -> all valids/readies 0 next cycle, then awready=arready=1.
//  6 wlast on beat 1 of an awlen=3 burst -> burst ends, bresp=SLVERR.

Source files
------------

// File: rtl/axi4_modport_slave_mem.sv
// axi4_modport_slave_mem: AXI4 slave over a word-addressed RAM, with independent single-burst write and read engines.
module axi4_modport_slave_mem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 4,
  parameter int USER_W    = 1,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                aclk_i,
  input  logic                areset_i,
  input  logic [ID_W-1:0]     awid_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic [7:0]          awlen_i,
  input  logic [2:0]          awsize_i,
  input  logic [1:0]          awburst_i,
  input  logic                awlock_i,
  input  logic [3:0]          awcache_i,
  input  logic [2:0]          awprot_i,
  input  logic [3:0]          awqos_i,
  input  logic [3:0]          awregion_i,
  input  logic [USER_W-1:0]   awuser_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wlast_i,
  input  logic [USER_W-1:0]   wuser_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [ID_W-1:0]     bid_o,
  output logic [1:0]          bresp_o,
  output logic [USER_W-1:0]   buser_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic [ID_W-1:0]     arid_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic [7:0]          arlen_i,
  input  logic [2:0]          arsize_i,
  input  logic [1:0]          arburst_i,
  input  logic                arlock_i,
  input  logic [3:0]          arcache_i,
  input  logic [2:0]          arprot_i,
  input  logic [3:0]          arqos_i,
  input  logic [3:0]          arregion_i,
  input  logic [USER_W-1:0]   aruser_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [ID_W-1:0]     rid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rlast_o,
  output logic [USER_W-1:0]   ruser_o,
  output logic                rvalid_o,
  input  logic                rready_i
);
  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int MW = $clog2(MEM_DEPTH);
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;
  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wst_e;
  typedef enum logic {RIDLE, RDATA} rdst_e;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  function automatic logic [ADDR_W-1:0] nxt_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                 input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W-1:0] inc, m;
    inc = ADDR_W'(1) << ((size > 3'(LB)) ? 3'(LB) : size);
    m = (ADDR_W'(len) + ADDR_W'(1)) * inc - ADDR_W'(1);
    return (burst == 2'b00) ? a : (burst == 2'b10) ? ((a & ~m) | ((a + inc) & m)) : a + inc;
  endfunction
  function automatic logic bad_burst(input logic [1:0] burst, input logic [7:0] len);
    return burst == 2'b11 || (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return (a >> LB) >= ADDR_W'(MEM_DEPTH);
  endfunction
  wst_e w_state_q, w_state_d;
  logic awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [ID_W-1:0] wid_q, bid_q, bid_d;
  logic [1:0] bresp_q, bresp_d, wburst_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0] wlen_q;
  logic [2:0] wsize_q;
  logic [8:0] wbeat_q;
  logic werr_q, aw_hs, w_hs, b_hs, w_oor, w_seq, w_en;
  assign aw_hs = awvalid_i && awready_q;
  assign w_hs  = wvalid_i && wready_q;
  assign b_hs  = bvalid_q && bready_i;
  assign w_oor = oor(waddr_q);
  // a beat count mismatch is flagged on the beat where it first becomes visible
  assign w_seq = wlast_i ? (wbeat_q != {1'b0, wlen_q}) : (wbeat_q >= {1'b0, wlen_q});
  assign w_en  = w_hs && !areset_i && !w_oor && (wbeat_q <= {1'b0, wlen_q});
  always_ff @(posedge aclk_i)
    if (areset_i) begin
      w_state_q <= WIDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= OKAY;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  always_comb
    w_state_d = (w_state_q == WIDLE && aw_hs) ? WDATA :
                (w_state_q == WDATA && w_hs && wlast_i) ? WRESP :
                (w_state_q == WRESP && b_hs) ? WIDLE : w_state_q;
  always_comb begin
    awready_d = w_state_d == WIDLE;
    wready_d  = w_state_d == WDATA;
    bvalid_d  = w_state_d == WRESP;
    bid_d     = (w_hs && wlast_i) ? wid_q : bid_q;
    bresp_d   = (w_hs && wlast_i) ? ((werr_q || w_oor || w_seq) ? SLVERR : OKAY) : bresp_q;
  end
  always_ff @(posedge aclk_i)
    if (areset_i) begin
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wsize_q  <= '0;
      wburst_q <= '0;
      wbeat_q  <= '0;
      werr_q   <= 1'b0;
    end else if (aw_hs) begin
      wid_q    <= awid_i;
      waddr_q  <= awaddr_i;
      wlen_q   <= awlen_i;
      wsize_q  <= awsize_i;
      wburst_q <= awburst_i;
      wbeat_q  <= '0;
      werr_q   <= bad_burst(awburst_i, awlen_i);
    end else if (w_hs) begin
      waddr_q <= nxt_addr(waddr_q, wlen_q, wsize_q, wburst_q);
      wbeat_q <= wbeat_q + 9'(wbeat_q != '1);
      werr_q  <= werr_q || w_oor || w_seq;
    end
  always_ff @(posedge aclk_i)
    if (w_en)
      for (int b = 0; b < NB; b++)
        if (wstrb_i[b]) mem[waddr_q[LB +: MW]][8*b +: 8] <= wdata_i[8*b +: 8];
  rdst_e r_state_q, r_state_d;
  logic arready_q, arready_d, rvalid_q, rvalid_d;
  logic [ID_W-1:0] rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0] rresp_q, rburst_q;
  logic [ADDR_W-1:0] raddr_q, r_la;
  logic [7:0] rlen_q, r_len, rbeat_q, r_beat;
  logic [2:0] rsize_q;
  logic rlast_q, rbad_q, r_bad, r_err, ar_hs, r_hs, r_ld;
  assign ar_hs = arvalid_i && arready_q;
  assign r_hs  = rvalid_q && rready_i;
  assign r_ld  = ar_hs || (r_hs && !rlast_q);
  // the beat loaded into the output register comes either from the new AR or from the advanced address
  always_comb begin
    r_la   = ar_hs ? araddr_i : nxt_addr(raddr_q, rlen_q, rsize_q, rburst_q);
    r_len  = ar_hs ? arlen_i : rlen_q;
    r_beat = ar_hs ? 8'd0 : rbeat_q + 8'd1;
    r_bad  = ar_hs ? bad_burst(arburst_i, arlen_i) : rbad_q;
    r_err  = r_bad || oor(r_la);
  end
  always_ff @(posedge aclk_i)
    if (areset_i) begin
      r_state_q <= RIDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  always_comb
    r_state_d = (r_state_q == RIDLE && ar_hs) ? RDATA :
                (r_state_q == RDATA && r_hs && rlast_q) ? RIDLE : r_state_q;
  always_comb begin
    arready_d = r_state_d == RIDLE;
    rvalid_d  = r_state_d == RDATA;
  end
  always_ff @(posedge aclk_i)
    if (areset_i) begin
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
      rlast_q  <= 1'b0;
      raddr_q  <= '0;
      rlen_q   <= '0;
      rsize_q  <= '0;
      rburst_q <= '0;
      rbeat_q  <= '0;
      rbad_q   <= 1'b0;
    end else if (r_ld) begin
      rid_q    <= ar_hs ? arid_i : rid_q;
      rsize_q  <= ar_hs ? arsize_i : rsize_q;
      rburst_q <= ar_hs ? arburst_i : rburst_q;
      raddr_q  <= r_la;
      rlen_q   <= r_len;
      rbeat_q  <= r_beat;
      rbad_q   <= r_bad;
      rdata_q  <= r_err ? '0 : mem[r_la[LB +: MW]];
      rresp_q  <= r_err ? SLVERR : OKAY;
      rlast_q  <= r_beat == r_len;
    end else if (r_hs) rlast_q <= 1'b0;
  assign awready_o = awready_q;
  assign wready_o  = wready_q;
  assign bvalid_o  = bvalid_q;
  assign bid_o     = bid_q;
  assign bresp_o   = bresp_q;
  assign buser_o   = '0;
  assign arready_o = arready_q;
  assign rvalid_o  = rvalid_q;
  assign rid_o     = rid_q;
  assign rdata_o   = rdata_q;
  assign rresp_o   = rresp_q;
  assign rlast_o   = rlast_q;
  assign ruser_o   = '0;
endmodule

// File: tb/tb_axi4_modport_slave_mem.sv
// tb_axi4_modport_slave_mem: directed and randomized bursts checked against an array model of the RAM.
module tb_axi4_modport_slave_mem;
  localparam int LIM = 200;
  logic aclk = 1'b0, areset = 1'b1;
  always #5 aclk = ~aclk;
  logic [3:0] awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0;
  logic [7:0] awlen = '0, arlen = '0, wstrb = '0;
  logic [2:0] awsize = '0, arsize = '0;
  logic [1:0] awburst = '0, arburst = '0, bresp, rresp;
  logic awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic awready, wready, bvalid, arready, rvalid, rlast, buser, ruser;
  logic [63:0] wdata = '0, rdata;
  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd_a [16];
  logic [1:0]  rr_a [16];
  logic        rl_a [16];
  logic [63:0] mdl [64];
  int n_asrt = 0, n_fail = 0;

  axi4_modport_slave_mem dut (
    .aclk_i(aclk), .areset_i(areset),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
    .awlock_i(1'b0), .awcache_i(4'h0), .awprot_i(3'h0), .awqos_i(4'h0), .awregion_i(4'h0), .awuser_i(1'b0),
    .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wuser_i(1'b0), .wvalid_i(wvalid), .wready_o(wready),
    .bid_o(bid), .bresp_o(bresp), .buser_o(buser), .bvalid_o(bvalid), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
    .arlock_i(1'b0), .arcache_i(4'h0), .arprot_i(3'h0), .arqos_i(4'h0), .arregion_i(4'h0), .aruser_i(1'b0),
    .arvalid_i(arvalid), .arready_o(arready),
    .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .ruser_o(ruser),
    .rvalid_o(rvalid), .rready_i(rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // byte address of beat i, derived from the burst definition rather than a running address
  function automatic int beat_addr(input int s, input int len, input int size, input int burst, input int i);
    int incr, tot, base;
    incr = 1 << (size > 3 ? 3 : size);
    if (burst == 0) return s;
    if (burst == 2) begin
      tot  = (len + 1) * incr;
      base = s - s % tot;
      return base + (s - base + i * incr) % tot;
    end
    return s + i * incr;
  endfunction

  task automatic mwrite(input int s, input int len, input int size, input int burst, input int nb);
    for (int i = 0; i < nb && i <= len; i++) begin
      int w;
      w = beat_addr(s, len, size, burst, i) / 8;
      if (w < 64)
        for (int b = 0; b < 8; b++) if (ws[i][b]) mdl[w][8*b +: 8] = wd[i][8*b +: 8];
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input int addr, input int len, input int size, input int burst,
                           input int nb, input int bhold, output logic [3:0] o_bid, output logic [1:0] o_bresp);
    int t;
    awid = id; awaddr = 32'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst); awvalid = 1'b1;
    t = 0;
    while (!awready && t < LIM) begin @(posedge aclk); #1; t++; end
    chk("aw_wait", 64'(t < LIM), 64'd1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    chk("aw_drop", 64'(awready), 64'd0);
    for (int i = 0; i < nb; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == nb - 1); wvalid = 1'b1;
      t = 0;
      while (!wready && t < LIM) begin @(posedge aclk); #1; t++; end
      chk("w_wait", 64'(t < LIM), 64'd1);
      @(posedge aclk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    t = 0;
    while (!bvalid && t < LIM) begin @(posedge aclk); #1; t++; end
    chk("b_wait", 64'(t < LIM), 64'd1);
    o_bid = bid; o_bresp = bresp;
    chk("buser", 64'(buser), 64'd0);
    for (int i = 0; i < bhold; i++) begin
      @(posedge aclk); #1;
      chk("b_hold_valid", 64'(bvalid), 64'd1);
      chk("b_hold_id", 64'(bid), 64'(id));
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("b_drop", 64'(bvalid), 64'd0);
    chk("aw_back", 64'(awready), 64'd1);
  endtask

  task automatic axi_read(input logic [3:0] id, input int addr, input int len, input int size, input int burst,
                          input int gap);
    int t;
    logic [63:0] hd;
    arid = id; araddr = 32'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst); arvalid = 1'b1;
    t = 0;
    while (!arready && t < LIM) begin @(posedge aclk); #1; t++; end
    chk("ar_wait", 64'(t < LIM), 64'd1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    chk("ar_drop", 64'(arready), 64'd0);
    rready = 1'b1;
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (!rvalid && t < LIM) begin @(posedge aclk); #1; t++; end
      chk("r_wait", 64'(t < LIM), 64'd1);
      rd_a[i] = rdata; rr_a[i] = rresp; rl_a[i] = rlast;
      chk("rid", 64'(rid), 64'(id));
      if (gap > 0 && i == 1) begin
        rready = 1'b0;
        hd = rdata;
        repeat (gap) begin
          @(posedge aclk); #1;
          chk("r_hold_valid", 64'(rvalid), 64'd1);
          chk("r_hold_data", rdata, hd);
          chk("r_hold_resp", 64'(rresp), 64'(rr_a[i]));
          chk("r_hold_last", 64'(rlast), 64'(rl_a[i]));
        end
        rready = 1'b1;
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    chk("r_drop", 64'(rvalid), 64'd0);
    chk("ar_back", 64'(arready), 64'd1);
  endtask

  task automatic cmp_read(input int s, input int len, input int size, input int burst);
    for (int i = 0; i <= len; i++) begin
      chk("rd_data", rd_a[i], mdl[beat_addr(s, len, size, burst, i) / 8]);
      chk("rd_resp", 64'(rr_a[i]), 64'd0);
      chk("rd_last", 64'(rl_a[i]), 64'(i == len));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] gb, id;
    logic [1:0] gr;
    int bu, ln, sz, st;
    int wrap_w [4] = '{3, 0, 1, 2};
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_arready", 64'(arready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rlast", 64'(rlast), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_bid", 64'({bid, bresp, rid, rresp}), 64'd0);
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("post_rst_awready", 64'(awready), 64'd1);
    chk("post_rst_arready", 64'(arready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
      axi_write(4'(k), k * 128, 15, 3, 1, 16, 0, gb, gr);
      chk("fill_bresp", 64'(gr), 64'd0);
      mwrite(k * 128, 15, 3, 1, 16);
    end
    // incrementing burst write/read
    wd[0] = {16{4'h1}}; wd[1] = {16{4'h2}}; wd[2] = {16{4'h3}}; wd[3] = {16{4'h4}};
    for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
    axi_write(4'h5, 'h100, 3, 3, 1, 4, 0, gb, gr);
    mwrite('h100, 3, 3, 1, 4);
    chk("t1_bresp", 64'(gr), 64'd0);
    chk("t1_bid", 64'(gb), 64'h5);
    axi_read(4'h6, 'h100, 3, 3, 1, 0);
    chk("t1_rd0", rd_a[0], {16{4'h1}});
    chk("t1_rd1", rd_a[1], {16{4'h2}});
    chk("t1_rd2", rd_a[2], {16{4'h3}});
    chk("t1_rd3", rd_a[3], {16{4'h4}});
    chk("t1_last", 64'({rl_a[0], rl_a[1], rl_a[2], rl_a[3]}), 64'b0001);
    chk("t1_resp", 64'({rr_a[0], rr_a[1], rr_a[2], rr_a[3]}), 64'd0);
    // byte strobes
    wd[0] = '1; ws[0] = 8'hFF;
    axi_write(4'h1, 0, 0, 3, 1, 1, 0, gb, gr);
    mwrite(0, 0, 3, 1, 1);
    wd[0] = '0; ws[0] = 8'h01;
    axi_write(4'h2, 0, 0, 3, 1, 1, 0, gb, gr);
    mwrite(0, 0, 3, 1, 1);
    axi_read(4'h3, 0, 0, 3, 1, 0);
    chk("t2_strobe", rd_a[0], 64'hFFFF_FFFF_FFFF_FF00);
    // wrapping and fixed reads
    axi_read(4'h7, 'h18, 3, 3, 2, 0);
    for (int i = 0; i < 4; i++) chk("t3_wrap", rd_a[i], mdl[wrap_w[i]]);
    chk("t3_wrap_last", 64'(rl_a[3]), 64'd1);
    axi_read(4'h8, 'h100, 2, 3, 0, 0);
    for (int i = 0; i < 3; i++) chk("t3_fixed", rd_a[i], {16{4'h1}});
    // out of range
    wd[0] = 64'hDEAD_BEEF_CAFE_F00D; ws[0] = 8'hFF;
    axi_write(4'hA, 1024 * 8, 0, 3, 1, 1, 0, gb, gr);
    chk("t4_bresp", 64'(gr), 64'd2);
    axi_read(4'hB, 0, 0, 3, 1, 0);
    chk("t4_ram_kept", rd_a[0], 64'hFFFF_FFFF_FFFF_FF00);
    axi_read(4'hC, 1024 * 8, 0, 3, 1, 0);
    chk("t4_rresp", 64'(rr_a[0]), 64'd2);
    chk("t4_rdata", rd_a[0], 64'd0);
    // early wlast
    for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
    axi_write(4'h3, 'h140, 3, 3, 1, 2, 0, gb, gr);
    mwrite('h140, 3, 3, 1, 2);
    chk("t6_bresp", 64'(gr), 64'd2);
    axi_read(4'h4, 'h140, 3, 3, 1, 0);
    cmp_read('h140, 3, 3, 1);
    // beats beyond awlen are not written
    axi_write(4'h9, 'h160, 1, 3, 1, 3, 0, gb, gr);
    mwrite('h160, 1, 3, 1, 3);
    chk("t7_bresp", 64'(gr), 64'd2);
    axi_read(4'h9, 'h160, 2, 3, 1, 0);
    cmp_read('h160, 2, 3, 1);
    axi_read(4'hD, 0, 1, 3, 3, 0);
    chk("rsv_rresp", 64'({rr_a[0], rr_a[1]}), 64'b1010);
    // backpressure
    wd[0] = {32{2'b10}}; ws[0] = 8'hFF;
    axi_write(4'hE, 'h108, 0, 3, 1, 1, 5, gb, gr);
    mwrite('h108, 0, 3, 1, 1);
    chk("t5_bid", 64'(gb), 64'hE);
    axi_read(4'hF, 'h100, 3, 3, 1, 3);
    cmp_read('h100, 3, 3, 1);
    // reset in the middle of a read burst
    arid = 4'h9; araddr = '0; arlen = 8'd7; arsize = 3'd3; arburst = 2'd1; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge aclk); #1;
    chk("t5_pre_rvalid", 64'(rvalid), 64'd1);
    areset = 1'b1;
    @(posedge aclk); #1;
    chk("t5_rst_rvalid", 64'(rvalid), 64'd0);
    chk("t5_rst_ready", 64'({awready, wready, arready, bvalid}), 64'd0);
    chk("t5_rst_rdata", rdata, 64'd0);
    chk("t5_rst_rlast", 64'(rlast), 64'd0);
    areset = 1'b0; rready = 1'b0;
    @(posedge aclk); #1;
    chk("t5_back_ready", 64'({awready, arready, rvalid}), 64'b110);
    // randomized bursts against the model
    for (int k = 0; k < 12; k++) begin
      bu = int'($urandom_range(0, 2));
      ln = int'($urandom_range(0, 15));
      sz = 3;
      if (bu == 2) begin
        ln = (2 << $urandom_range(0, 3)) - 1;
        st = int'($urandom_range(0, 63)) * 8;
      end else if (bu == 1) begin
        sz = int'($urandom_range(0, 3));
        st = int'($urandom_range(0, 511 - ln * (1 << sz)));
      end else st = int'($urandom_range(0, 511));
      for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
      id = 4'($urandom);
      axi_write(id, st, ln, sz, bu, ln + 1, 0, gb, gr);
      mwrite(st, ln, sz, bu, ln + 1);
      chk("rnd_bid", 64'(gb), 64'(id));
      chk("rnd_bresp", 64'(gr), 64'd0);
      axi_read(id + 4'd1, st, ln, sz, bu, k % 3);
      cmp_read(st, ln, sz, bu);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
